// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the stream encrypter/decrypter pair.
// Combinational helpers only; no latency, no flow control.
package lfsr_pkg;

    localparam logic [7:0] TAP_MASK_DEFAULT = 8'hE1;
    localparam logic [7:0] LFSR_RESET_SEED  = 8'h41;

    typedef enum logic [2:0] {
        HUNT,
        SEED,
        LEN,
        DATA,
        CHECK
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ZERO    = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Fibonacci step: shift left, feedback is parity of the tapped bits.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q, input logic [7:0] taps);
        return {q[6:0], ^(q & taps)};
    endfunction

endpackage

// File: rtl/lfsr_keystream.sv
// 8-bit Fibonacci keystream register: load a seed or advance one step per cycle.
// q_o updates one cycle after load_i/advance_i; no flow control, load wins over advance.
module lfsr_keystream
    import lfsr_pkg::*;
#(
    parameter logic [7:0] TAP_MASK = TAP_MASK_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       advance_i,
    output logic [7:0] q_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = seed_i;
        end else if (advance_i) begin
            q_d = lfsr_step(q_q, TAP_MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= LFSR_RESET_SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// Framed LFSR stream decrypter with XOR checksum check and inter-byte timeout.
// Plaintext one cycle after accept; in_ready drops in DATA only while the output register is stalled.
module lfsr_stream_decrypt
    import lfsr_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  TAP_MASK       = TAP_MASK_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [7:0]    rem_q, rem_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          accept;
    logic [7:0]    plain;
    logic          ks_load;
    logic          ks_adv;
    logic [7:0]    ks_q;

    lfsr_keystream #(.TAP_MASK(TAP_MASK)) u_ks (
        .clk       (clk),
        .rst       (rst),
        .load_i    (ks_load),
        .seed_i    (in_data),
        .advance_i (ks_adv),
        .q_o       (ks_q)
    );

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        csum_d      = csum_q;
        to_d        = to_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_valid_d ? out_last_q : 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        code_d      = ERR_NONE;
        ks_load     = 1'b0;
        ks_adv      = 1'b0;
        in_ready    = (state_q == DATA) ? (~out_valid_q | out_ready) : 1'b1;
        accept      = in_valid & in_ready;
        plain       = in_data ^ ks_q;

        case (state_q)
            HUNT: begin
                if (accept && in_data == SYNC_BYTE) state_d = SEED;
            end
            SEED: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        err_d   = 1'b1;
                        code_d  = ERR_ZERO;
                        state_d = HUNT;
                    end else begin
                        ks_load = 1'b1;
                        state_d = LEN;
                    end
                end
            end
            LEN: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        err_d   = 1'b1;
                        code_d  = ERR_ZERO;
                        state_d = HUNT;
                    end else begin
                        rem_d   = in_data;
                        csum_d  = 8'h00;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = plain;
                    out_last_d  = (rem_q == 8'd1);
                    csum_d      = csum_q ^ plain;
                    rem_d       = rem_q - 8'd1;
                    ks_adv      = 1'b1;
                    if (rem_q == 8'd1) state_d = CHECK;
                end
            end
            CHECK: begin
                if (accept) begin
                    done_d  = 1'b1;
                    state_d = HUNT;
                    if (in_data != csum_q) begin
                        err_d  = 1'b1;
                        code_d = ERR_CSUM;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // Idle-cycle watchdog; an accept always clears it, so it can never race a timeout.
        if (state_q == HUNT || accept) begin
            to_d = '0;
        end else if (in_ready && !in_valid) begin
            if (to_q == TO_LAST) begin
                to_d    = '0;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = HUNT;
            end else begin
                to_d = to_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            rem_q       <= 8'h00;
            csum_q      <= 8'h00;
            to_q        <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            csum_q      <= csum_d;
            to_q        <= to_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Directed bench for lfsr_stream_decrypt: table of whole frames plus backpressure, timeout and reset sequences.
module tb_lfsr_stream_decrypt;
    import lfsr_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    lfsr_stream_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    typedef struct {
        int         nb;
        logic [7:0] b [10];
        int         nout;
        logic [7:0] exp [3];
        int         done;
        int         err;
        logic [1:0] code;
    } vec_t;

    vec_t vecs [7];
    int   checks   = 0;
    int   failures = 0;

    logic [8:0] obs_q [$];
    int         done_cnt  = 0;
    int         err_cnt   = 0;
    logic [1:0] last_code = 2'b00;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
            if (frame_done) done_cnt++;
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Entered and left at posedge+1; holds the byte until the block takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n        = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL send_byte_stall actual=in_ready_low expected=accept_within_100");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_window(input string nm, input vec_t vv, input int q0, input int d0, input int e0);
        chk({nm, "_nout"}, obs_q.size() - q0, vv.nout);
        for (int i = 0; i < vv.nout; i++) begin
            if (q0 + i < obs_q.size()) begin
                chk($sformatf("%s_data%0d", nm, i), obs_q[q0+i][7:0], vv.exp[i]);
                chk($sformatf("%s_last%0d", nm, i), obs_q[q0+i][8], (i == vv.nout - 1));
            end
        end
        chk({nm, "_done"}, done_cnt - d0, vv.done);
        chk({nm, "_err"}, err_cnt - e0, vv.err);
        if (vv.err != 0) chk({nm, "_code"}, last_code, vv.code);
    endtask

    task automatic run_vec(input string nm, input vec_t vv);
        int q0, d0, e0;
        q0 = obs_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < vv.nb; i++) send_byte(vv.b[i]);
        repeat (3) @(posedge clk);
        #1;
        check_window(nm, vv, q0, d0, e0);
    endtask

    initial begin
        int q0, d0, e0;

        vecs[0] = '{nb: 7, b: '{8'hA5, 8'h41, 8'h03, 8'h50, 8'hA0, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00},
                    nout: 3, exp: '{8'h11, 8'h22, 8'h33}, done: 1, err: 0, code: 2'b00};
        vecs[1] = '{nb: 7, b: '{8'hA5, 8'h41, 8'h03, 8'h50, 8'hA0, 8'h36, 8'hFF, 8'h00, 8'h00, 8'h00},
                    nout: 3, exp: '{8'h11, 8'h22, 8'h33}, done: 1, err: 1, code: 2'b10};
        vecs[2] = '{nb: 2, b: '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nout: 0, exp: '{8'h00, 8'h00, 8'h00}, done: 0, err: 1, code: 2'b01};
        vecs[3] = '{nb: 3, b: '{8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nout: 0, exp: '{8'h00, 8'h00, 8'h00}, done: 0, err: 1, code: 2'b01};
        vecs[4] = '{nb: 9, b: '{8'h00, 8'h13, 8'hA5, 8'h41, 8'h03, 8'h50, 8'hA0, 8'h36, 8'h00, 8'h00},
                    nout: 3, exp: '{8'h11, 8'h22, 8'h33}, done: 1, err: 0, code: 2'b00};
        vecs[5] = '{nb: 6, b: '{8'hA5, 8'h82, 8'h02, 8'h00, 8'h00, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00},
                    nout: 2, exp: '{8'h82, 8'h05, 8'h00}, done: 1, err: 0, code: 2'b00};
        vecs[6] = '{nb: 5, b: '{8'hA5, 8'h41, 8'h01, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    nout: 1, exp: '{8'h00, 8'h00, 8'h00}, done: 1, err: 0, code: 2'b00};

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_err_code", err_code, 2'b00);
        chk("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 7; v++) run_vec($sformatf("vec%0d", v), vecs[v]);

        // Output stall on the second plaintext byte.
        q0 = obs_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'h03);
        send_byte(8'h50);
        send_byte(8'hA0);
        out_ready = 1'b0;
        in_data   = 8'h36;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), out_valid, 1'b1);
            chk($sformatf("bp_data%0d", i), out_data, 8'h22);
            chk($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send_byte(8'h36);
        send_byte(8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_window("bp", vecs[0], q0, d0, e0);

        // Leading junk, then a truncated frame left idle until the watchdog fires.
        q0 = obs_q.size();
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'h02);
        repeat (1023) @(posedge clk);
        #1;
        chk("to_early", frame_err, 1'b0);
        @(posedge clk);
        #1;
        chk("to_fire", frame_err, 1'b1);
        chk("to_code", err_code, 2'b11);
        @(posedge clk);
        #1;
        chk("to_pulse_end", frame_err, 1'b0);
        chk("to_no_output", obs_q.size() - q0, 0);
        run_vec("after_to", vecs[0]);

        // Reset while the first plaintext byte is pending.
        send_byte(8'hA5);
        send_byte(8'h41);
        send_byte(8'h03);
        send_byte(8'h50);
        chk("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_valid", out_valid, 1'b0);
        chk("post_rst_state", 32'(dut.state_q), 32'(HUNT));
        chk("post_rst_ks", dut.ks_q, 8'h41);
        @(posedge clk);
        #1;
        run_vec("after_rst", vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
